// File: rtl/spi_rd_target_pkg.sv
// Shared opcodes, FSM state encoding and counter widths for the SPI read target.
package spi_rd_target_pkg;

  localparam logic [7:0] CMD_READ     = 8'h03;
  localparam logic [7:0] CMD_FASTREAD = 8'h0B;

  // Wide enough to count the 24 address bits.
  localparam int BCNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/spi_rd_target_sync.sv
// Oversampling front end: synchronizes SCK/CSB/SDI into core_clk and produces
// registered one-cycle edge strobes, all aligned with the synchronized SDI level.
module spi_rd_target_sync
  import spi_rd_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck_i,
  input  logic csb_i,
  input  logic sdi_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic csb_rise_o,
  output logic csb_fall_o,
  output logic csb_lvl_o,
  output logic sdi_o
);

  logic [SYNC_STAGES-1:0] sck_s_q;
  logic [SYNC_STAGES-1:0] csb_s_q;
  logic [SYNC_STAGES-1:0] sdi_s_q;
  logic                   sck_h_q;
  logic                   csb_h_q;
  logic                   sdi_q;
  logic                   sck_rise_q;
  logic                   sck_fall_q;
  logic                   csb_rise_q;
  logic                   csb_fall_q;

  // CSB resets low so a high pin after reset yields a rise strobe, which arms the target.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_s_q    <= '0;
      csb_s_q    <= '0;
      sck_h_q    <= 1'b0;
      csb_h_q    <= 1'b0;
      sck_rise_q <= 1'b0;
      sck_fall_q <= 1'b0;
      csb_rise_q <= 1'b0;
      csb_fall_q <= 1'b0;
    end else begin
      sck_s_q    <= {sck_s_q[SYNC_STAGES-2:0], sck_i};
      csb_s_q    <= {csb_s_q[SYNC_STAGES-2:0], csb_i};
      sck_h_q    <= sck_s_q[SYNC_STAGES-1];
      csb_h_q    <= csb_s_q[SYNC_STAGES-1];
      sck_rise_q <= sck_s_q[SYNC_STAGES-1] & ~sck_h_q;
      sck_fall_q <= ~sck_s_q[SYNC_STAGES-1] & sck_h_q;
      csb_rise_q <= csb_s_q[SYNC_STAGES-1] & ~csb_h_q;
      csb_fall_q <= ~csb_s_q[SYNC_STAGES-1] & csb_h_q;
    end
  end

  always_ff @(posedge clk_i) begin
    sdi_s_q <= {sdi_s_q[SYNC_STAGES-2:0], sdi_i};
    sdi_q   <= sdi_s_q[SYNC_STAGES-1];
  end

  assign sck_rise_o = sck_rise_q;
  assign sck_fall_o = sck_fall_q;
  assign csb_rise_o = csb_rise_q;
  assign csb_fall_o = csb_fall_q;
  assign csb_lvl_o  = csb_h_q;
  assign sdi_o      = sdi_q;

endmodule

// File: rtl/spi_rd_target.sv
// SPI mode-0 read-only target: READ (0x03) + 24-bit address, byte prefetch via mem port.
// Define SPI_RD_TARGET_FASTREAD_EN to also accept FAST READ (0x0B) with 8 dummy clocks.
module spi_rd_target
  import spi_rd_target_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              core_clk,
  input  logic              core_rst,
  input  logic              spi_sck,
  input  logic              spi_csb,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              spi_sdoenb,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic [7:0]        last_cmd,
  output logic              err_unsup,
  output logic              err_under
);

  localparam int SH_W = ADDR_W - 1;

  logic sck_rise;
  logic sck_fall;
  logic csb_rise;
  logic csb_fall;
  logic csb_lvl;
  logic sdi_s;

  spi_rd_target_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i      (core_clk),
    .rst_i      (core_rst),
    .sck_i      (spi_sck),
    .csb_i      (spi_csb),
    .sdi_i      (spi_sdi),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .csb_rise_o (csb_rise),
    .csb_fall_o (csb_fall),
    .csb_lvl_o  (csb_lvl),
    .sdi_o      (sdi_s)
  );

  state_e              state_q;
  logic [BCNT_W-1:0]   bit_cnt_q;
  logic [SH_W-1:0]     shift_q;
  logic [7:0]          last_cmd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_req_q;
  logic [7:0]          nxt_q;
  logic                nxt_vld_q;
  logic [7:0]          tx_q;
  logic [2:0]          tx_cnt_q;
  logic                fast_q;
  logic                sdo_q;
  logic                sdoenb_q;
  logic                busy_q;
  logic                armed_q;
  logic                err_unsup_q;
  logic                err_under_q;

  logic [SH_W-1:0]     shift_d;
  logic [7:0]          cmd_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [ADDR_W-1:0]   addr_inc_d;

  always_comb begin
    shift_d    = {shift_q[SH_W-2:0], sdi_s};
    cmd_d      = {shift_q[6:0], sdi_s};
    addr_d     = {shift_q, sdi_s};
    addr_inc_d = addr_q + 1'b1;
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      last_cmd_q  <= '0;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      nxt_q       <= '0;
      nxt_vld_q   <= 1'b0;
      tx_q        <= '0;
      tx_cnt_q    <= '0;
      fast_q      <= 1'b0;
      sdo_q       <= 1'b0;
      sdoenb_q    <= 1'b1;
      busy_q      <= 1'b0;
      armed_q     <= 1'b0;
      err_unsup_q <= 1'b0;
      err_under_q <= 1'b0;
    end else begin
      err_unsup_q <= 1'b0;
      err_under_q <= 1'b0;
      busy_q      <= armed_q & ~csb_lvl;
      if (csb_rise) armed_q <= 1'b1;

      if (mem_req_q && mem_ack) begin
        nxt_q     <= mem_rdata;
        nxt_vld_q <= 1'b1;
        mem_req_q <= 1'b0;
      end

      // Deselect overrides everything, including a same-cycle mem_ack.
      if (csb_rise) begin
        state_q   <= ST_IDLE;
        mem_req_q <= 1'b0;
        nxt_vld_q <= 1'b0;
        sdoenb_q  <= 1'b1;
        sdo_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (csb_fall && armed_q) begin
              state_q   <= ST_CMD;
              bit_cnt_q <= '0;
            end
          end
          ST_CMD: begin
            if (sck_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == BCNT_W'(7)) begin
                last_cmd_q <= cmd_d;
                bit_cnt_q  <= '0;
                if (cmd_d == CMD_READ) begin
                  state_q <= ST_ADDR;
                  fast_q  <= 1'b0;
                end
`ifdef SPI_RD_TARGET_FASTREAD_EN
                else if (cmd_d == CMD_FASTREAD) begin
                  state_q <= ST_ADDR;
                  fast_q  <= 1'b1;
                end
`endif
                else begin
                  state_q     <= ST_IGNORE;
                  err_unsup_q <= 1'b1;
                end
              end
            end
          end
          ST_ADDR: begin
            if (sck_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == BCNT_W'(23)) begin
                addr_q     <= addr_d;
                mem_addr_q <= addr_d;
                mem_req_q  <= 1'b1;
                nxt_vld_q  <= 1'b0;
                bit_cnt_q  <= '0;
                tx_cnt_q   <= '0;
                if (fast_q) begin
                  state_q <= ST_DUMMY;
                end else begin
                  state_q  <= ST_DATA;
                  sdoenb_q <= 1'b0;
                end
              end
            end
          end
          ST_DUMMY: begin
            if (sck_rise) begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == BCNT_W'(7)) begin
                state_q  <= ST_DATA;
                sdoenb_q <= 1'b0;
                tx_cnt_q <= '0;
              end
            end
          end
          ST_DATA: begin
            if (sck_fall) begin
              if (tx_cnt_q == 3'd0) begin
                tx_cnt_q <= 3'd7;
                if (nxt_vld_q) begin
                  sdo_q      <= nxt_q[7];
                  tx_q       <= {nxt_q[6:0], 1'b1};
                  nxt_vld_q  <= 1'b0;
                  addr_q     <= addr_inc_d;
                  mem_addr_q <= addr_inc_d;
                  mem_req_q  <= 1'b1;
                end else begin
                  // Underrun: emit all-ones, leave the outstanding fetch for the next byte.
                  sdo_q       <= 1'b1;
                  tx_q        <= 8'hFF;
                  err_under_q <= 1'b1;
                end
              end else begin
                sdo_q    <= tx_q[7];
                tx_q     <= {tx_q[6:0], 1'b1};
                tx_cnt_q <= tx_cnt_q - 1'b1;
              end
            end
          end
          ST_IGNORE: begin
            state_q <= ST_IGNORE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign spi_sdo    = sdo_q;
  assign spi_sdoenb = sdoenb_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign busy       = busy_q;
  assign last_cmd   = last_cmd_q;
  assign err_unsup  = err_unsup_q;
  assign err_under  = err_under_q;

endmodule

// File: tb/tb_spi_rd_target.sv
// Directed bench for spi_rd_target: SPI master driving SCK at core_clk/10 plus a
// delayed-ack memory model; honours SPI_RD_TARGET_FASTREAD_EN like the RTL.
module tb_spi_rd_target;

  logic        clk = 1'b0;
  logic        core_rst;
  logic        sck;
  logic        csb;
  logic        sdi;
  logic        sdo;
  logic        sdoenb;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic [7:0]  last_cmd;
  logic        err_unsup;
  logic        err_under;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] ack_addr_q [$];
  int          ack_delay = 2;
  int          wait_cnt  = 0;
  int          unsup_cnt = 0;
  int          under_cnt = 0;
  int          enb_cnt   = 0;
  int          req_cnt   = 0;

  always #5 clk = ~clk;

  spi_rd_target #(
    .ADDR_W      (16),
    .SYNC_STAGES (2)
  ) dut (
    .core_clk   (clk),
    .core_rst   (core_rst),
    .spi_sck    (sck),
    .spi_csb    (csb),
    .spi_sdi    (sdi),
    .spi_sdo    (sdo),
    .spi_sdoenb (sdoenb),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .last_cmd   (last_cmd),
    .err_unsup  (err_unsup),
    .err_under  (err_under)
  );

  // Memory model: ack ack_delay cycles after mem_req is seen.
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_req) begin
      wait_cnt++;
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        ack_addr_q.push_back(mem_addr);
      end
    end else begin
      wait_cnt = 0;
    end
  end

  always @(posedge clk) begin
    if (err_unsup === 1'b1) unsup_cnt++;
    if (err_under === 1'b1) under_cnt++;
    if (sdoenb === 1'b0)    enb_cnt++;
    if (mem_req === 1'b1)   req_cnt++;
  end

  task automatic spi_bits(input int n, input logic [31:0] tx, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      sdi = tx[i];
      repeat (5) @(negedge clk);
      rx[i] = sdo;
      sck = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic spi_byte(output logic [7:0] rx);
    logic [31:0] r;
    spi_bits(8, 32'd0, r);
    rx = r[7:0];
  endtask

  task automatic csb_start();
    @(negedge clk);
    csb = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic csb_end();
    repeat (5) @(negedge clk);
    csb = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    logic [31:0] r;
    spi_bits(8, {24'd0, cmd}, r);
    spi_bits(24, {8'd0, a}, r);
  endtask

  task automatic test_reset();
    core_rst = 1'b1;
    sck = 1'b0;
    csb = 1'b1;
    sdi = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    repeat (6) @(negedge clk);
    chk_cnt++; if (sdo !== 1'b0) $display("FAIL reset_sdo got %b exp 0", sdo); else pass_cnt++;
    chk_cnt++; if (sdoenb !== 1'b1) $display("FAIL reset_sdoenb got %b exp 1", sdoenb); else pass_cnt++;
    chk_cnt++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %b exp 0", mem_req); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 16'h0000) $display("FAIL reset_mem_addr got %h exp 0000", mem_addr); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    chk_cnt++; if (last_cmd !== 8'h00) $display("FAIL reset_last_cmd got %h exp 00", last_cmd); else pass_cnt++;
    chk_cnt++; if ({err_unsup, err_under} !== 2'b00) $display("FAIL reset_err got %b exp 00", {err_unsup, err_under}); else pass_cnt++;
    core_rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_read_seq();
    logic [7:0] exp [11] = '{8'h93, 8'h01, 8'h00, 8'h13, 8'h02, 8'h63, 8'h57, 8'hB5, 8'h00, 8'h23, 8'h20};
    logic [7:0] rx;
    int u0 = unsup_cnt;
    int d0 = under_cnt;
    csb_start();
    chk_cnt++; if (busy !== 1'b1) $display("FAIL t1_busy got %b exp 1", busy); else pass_cnt++;
    send_hdr(8'h03, 24'h000000);
    for (int i = 0; i < 11; i++) begin
      spi_byte(rx);
      chk_cnt++;
      if (rx !== exp[i]) $display("FAIL t1_byte%0d got %h exp %h", i, rx, exp[i]);
      else pass_cnt++;
    end
    csb_end();
    chk_cnt++; if (last_cmd !== 8'h03) $display("FAIL t1_last_cmd got %h exp 03", last_cmd); else pass_cnt++;
    chk_cnt++; if ((unsup_cnt - u0) + (under_cnt - d0) !== 0)
      $display("FAIL t1_err_pulses got %0d exp 0", (unsup_cnt - u0) + (under_cnt - d0)); else pass_cnt++;
  endtask

  task automatic test_unsupported();
    logic [31:0] r;
    int u0 = unsup_cnt;
    int e0 = enb_cnt;
    int q0 = req_cnt;
    csb_start();
    spi_bits(8, 32'h9F, r);
    spi_bits(24, 32'h123456, r);
    csb_end();
    chk_cnt++; if (unsup_cnt - u0 !== 1) $display("FAIL t2_err_unsup got %0d exp 1", unsup_cnt - u0); else pass_cnt++;
    chk_cnt++; if (enb_cnt - e0 !== 0) $display("FAIL t2_sdoenb_low got %0d exp 0", enb_cnt - e0); else pass_cnt++;
    chk_cnt++; if (req_cnt - q0 !== 0) $display("FAIL t2_mem_req got %0d exp 0", req_cnt - q0); else pass_cnt++;
    chk_cnt++; if (last_cmd !== 8'h9F) $display("FAIL t2_last_cmd got %h exp 9F", last_cmd); else pass_cnt++;
  endtask

  task automatic test_addr_wrap();
    logic [7:0] rx0, rx1;
    int base = ack_addr_q.size();
    csb_start();
    send_hdr(8'h03, 24'h00FFFF);
    spi_byte(rx0);
    spi_byte(rx1);
    csb_end();
    chk_cnt++; if (rx0 !== 8'hA5) $display("FAIL t3_byte0 got %h exp A5", rx0); else pass_cnt++;
    chk_cnt++; if (rx1 !== 8'h93) $display("FAIL t3_byte1 got %h exp 93", rx1); else pass_cnt++;
    chk_cnt++;
    if (ack_addr_q.size() < base + 2) $display("FAIL t3_ack_count got %0d exp >=2", ack_addr_q.size() - base);
    else if (ack_addr_q[base] !== 16'hFFFF) $display("FAIL t3_addr0 got %h exp FFFF", ack_addr_q[base]);
    else pass_cnt++;
    chk_cnt++;
    if (ack_addr_q.size() < base + 2) $display("FAIL t3_addr1 missing got %0d acks exp >=2", ack_addr_q.size() - base);
    else if (ack_addr_q[base + 1] !== 16'h0000) $display("FAIL t3_addr1 got %h exp 0000", ack_addr_q[base + 1]);
    else pass_cnt++;
  endtask

  task automatic test_underrun();
    logic [7:0] rx0, rx1;
    int d0 = under_cnt;
    ack_delay = 40;
    csb_start();
    send_hdr(8'h03, 24'h000003);
    spi_byte(rx0);
    spi_byte(rx1);
    csb_end();
    ack_delay = 2;
    chk_cnt++; if (rx0 !== 8'hFF) $display("FAIL t4_byte0 got %h exp FF", rx0); else pass_cnt++;
    chk_cnt++; if (rx1 !== 8'h13) $display("FAIL t4_byte1 got %h exp 13", rx1); else pass_cnt++;
    chk_cnt++; if (under_cnt - d0 !== 1) $display("FAIL t4_err_under got %0d exp 1", under_cnt - d0); else pass_cnt++;
  endtask

  task automatic test_abort_then_read();
    logic [31:0] r;
    logic [7:0]  rx;
    int u0 = unsup_cnt;
    int d0 = under_cnt;
    csb_start();
    spi_bits(8, 32'h03, r);
    spi_bits(12, 32'hABC, r);
    csb_end();
    csb_start();
    send_hdr(8'h03, 24'h000004);
    spi_byte(rx);
    csb_end();
    chk_cnt++; if (rx !== 8'h02) $display("FAIL t5_byte0 got %h exp 02", rx); else pass_cnt++;
    chk_cnt++; if ((unsup_cnt - u0) + (under_cnt - d0) !== 0)
      $display("FAIL t5_err_pulses got %0d exp 0", (unsup_cnt - u0) + (under_cnt - d0)); else pass_cnt++;
  endtask

  task automatic test_fastread();
    logic [31:0] r;
    logic [7:0]  rx0, rx1;
    int u0 = unsup_cnt;
    int e0 = enb_cnt;
    csb_start();
    send_hdr(8'h0B, 24'h000007);
`ifdef SPI_RD_TARGET_FASTREAD_EN
    spi_bits(7, 32'd0, r);
    chk_cnt++; if (enb_cnt - e0 !== 0) $display("FAIL t6_dummy_sdoenb got %0d low cycles exp 0", enb_cnt - e0); else pass_cnt++;
    spi_bits(1, 32'd0, r);
    spi_byte(rx0);
    spi_byte(rx1);
    csb_end();
    chk_cnt++; if (rx0 !== 8'hB5) $display("FAIL t6_byte0 got %h exp B5", rx0); else pass_cnt++;
    chk_cnt++; if (rx1 !== 8'h00) $display("FAIL t6_byte1 got %h exp 00", rx1); else pass_cnt++;
    chk_cnt++; if (unsup_cnt - u0 !== 0) $display("FAIL t6_err_unsup got %0d exp 0", unsup_cnt - u0); else pass_cnt++;
`else
    spi_bits(16, 32'd0, r);
    rx0 = r[7:0];
    rx1 = rx0;
    csb_end();
    chk_cnt++; if (unsup_cnt - u0 !== 1) $display("FAIL t6_err_unsup got %0d exp 1", unsup_cnt - u0); else pass_cnt++;
    chk_cnt++; if (enb_cnt - e0 !== 0) $display("FAIL t6_sdoenb_low got %0d exp 0", enb_cnt - e0); else pass_cnt++;
`endif
    chk_cnt++; if (last_cmd !== 8'h0B) $display("FAIL t6_last_cmd got %h exp 0B", last_cmd); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'h93; mem[1] = 8'h01; mem[2] = 8'h00; mem[3]  = 8'h13;
    mem[4] = 8'h02; mem[5] = 8'h63; mem[6] = 8'h57; mem[7]  = 8'hB5;
    mem[8] = 8'h00; mem[9] = 8'h23; mem[10] = 8'h20;
    mem[16'hFFFF] = 8'hA5;

    test_reset();
    test_read_seq();
    test_unsupported();
    test_addr_wrap();
    test_underrun();
    test_abort_then_read();
    test_fastread();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
